// File: rtl/wide_alu_seq.sv
// ---------------------------------------------------------------------------
// wide_alu_seq
//   Sequences an external combinational 8-bit ALU across a W = 8*BYTES wide
//   operation, one byte per clock. Add/sub and the shift classes chain the
//   carry from byte to byte, and bitwise ops apply the request carry-in to
//   every byte. Right shifts walk from the top byte down. Every other class
//   walks from the bottom byte up.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, not in reset)
//   req_a, req_b          W-bit operands
//   req_op                4-bit ALU opcode, applied to each byte
//   req_cin               carry-in for the wide operation
//   res_valid/res_ready   result handshake (valid while in DONE)
//   res_q, res_cout       W-bit result and wide carry-out. Both hold their
//                         value until the next operation overwrites them.
//   alu_a/b/op/cin        drive to the 8-bit ALU (all zero outside RUN)
//   alu_q, alu_cout       same-cycle response from the 8-bit ALU
// ---------------------------------------------------------------------------
module wide_alu_seq #(
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [8*BYTES-1:0] req_a,
  input  logic [8*BYTES-1:0] req_b,
  input  logic [3:0]         req_op,
  input  logic               req_cin,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [8*BYTES-1:0] res_q,
  output logic               res_cout,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_op,
  output logic               alu_cin,
  input  logic [7:0]         alu_q,
  input  logic               alu_cout
);

  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  a_q, b_q;
  logic [3:0]    op_q;
  logic          cin_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    res_byte_q [BYTES];
  logic          res_cout_q;

  logic [7:0]    a_byte [BYTES];
  logic [7:0]    b_byte [BYTES];
  logic          descending;
  logic          last_step;

  // Byte views of the latched operands, and the result assembled from bytes.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
      assign a_byte[gi]         = a_q[8*gi +: 8];
      assign b_byte[gi]         = b_q[8*gi +: 8];
      assign res_q[8*gi +: 8]   = res_byte_q[gi];
    end
  endgenerate

  assign descending = (op_q[3:2] == 2'b11);
  assign last_step  = descending ? (idx_q == '0) : (idx_q == LAST_IDX);

  assign req_ready = (state_q == IDLE) && !rst;
  assign res_valid = (state_q == DONE);
  assign res_cout  = res_cout_q;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_a  = a_byte[idx_q];
      alu_b  = b_byte[idx_q];
      alu_op = op_q;
      // Upper bytes of add/sub must consume the incoming carry even when
      // the requested op ignores carry-in for the bottom byte.
      if (op_q[3:2] == 2'b00 && idx_q != '0)
        alu_op = {op_q[3:1], 1'b1};
      alu_cin = (op_q[3:2] == 2'b01) ? cin_q : carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cin_q      <= 1'b0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      res_cout_q <= 1'b0;
      for (int i = 0; i < BYTES; i++) res_byte_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            op_q    <= req_op;
            cin_q   <= req_cin;
            carry_q <= req_cin;
            idx_q   <= (req_op[3:2] == 2'b11) ? LAST_IDX : '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_byte_q[idx_q] <= alu_q;
          carry_q           <= alu_cout;
          if (last_step) begin
            res_cout_q <= alu_cout;
            state_q    <= DONE;
          end else begin
            idx_q <= descending ? (idx_q - 1'b1) : (idx_q + 1'b1);
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_alu_seq.sv
module tb_wide_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_op;
  logic        req_cin;
  logic        res_valid, res_ready;
  logic [15:0] res_q;
  logic        res_cout;
  logic [7:0]  alu_a, alu_b, alu_q;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wide_alu_seq #(.BYTES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_q(res_q), .res_cout(res_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_q(alu_q), .alu_cout(alu_cout)
  );

  // 8-bit reference ALU attached to the DUT.
  //   00xx : add/sub. op[1]=subtract (a + ~b), op[0]=use cin, and otherwise
  //          the implied carry is op[1].
  //   01xx : and / or / xor / xor-with-cin-mask, cout=0
  //   10xx : shift left,  cin into bit0, bit7 out
  //   11xx : shift right, cin into bit7, bit0 out
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum  = '0;
    alu_q    = '0;
    alu_cout = 1'b0;
    case (alu_op[3:2])
      2'b00: begin
        alu_sum  = {1'b0, alu_a} + {1'b0, (alu_op[1] ? ~alu_b : alu_b)}
                 + {8'b0, (alu_op[0] ? alu_cin : alu_op[1])};
        alu_q    = alu_sum[7:0];
        alu_cout = alu_sum[8];
      end
      2'b01: begin
        case (alu_op[1:0])
          2'b00:   alu_q = alu_a & alu_b;
          2'b01:   alu_q = alu_a | alu_b;
          2'b10:   alu_q = alu_a ^ alu_b;
          default: alu_q = alu_a ^ alu_b ^ {8{alu_cin}};
        endcase
      end
      2'b10: begin
        alu_q    = {alu_a[6:0], alu_cin};
        alu_cout = alu_a[7];
      end
      default: begin
        alu_q    = {alu_cin, alu_a[7:1]};
        alu_cout = alu_a[0];
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Values observed during the two RUN cycles of the last operation.
  logic [7:0] step_a0, step_a1;
  logic [3:0] step_op0, step_op1;
  logic       step_cin0, step_cin1;
  logic       rv0, rv1;

  // Offers one request and returns at the sample point 2 edges after the
  // acceptance edge, where the result must be valid.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin);
    int n;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble the request; the latched copy must be used.
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op; req_cin = ~cin;
    step_a0 = alu_a; step_op0 = alu_op; step_cin0 = alu_cin; rv0 = res_valid;
    @(posedge clk); #1;
    step_a1 = alu_a; step_op1 = alu_op; step_cin1 = alu_cin; rv1 = res_valid;
    @(posedge clk); #1;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("valid_drop", {31'b0, res_valid}, 32'd0);
    check("idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] q;
    logic        cout;
  } vec_t;

  vec_t vecs [12];

  int          last_acc, n_acc, n_res;
  logic [15:0] exp_sum;

  initial begin
    vecs[0]  = '{4'b0000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[1]  = '{4'b0000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{4'b0001, 16'h1234, 16'h0FF0, 1'b1, 16'h2225, 1'b0};
    vecs[3]  = '{4'b0010, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1};
    vecs[4]  = '{4'b0100, 16'hF0F0, 16'hFF0F, 1'b0, 16'hF000, 1'b0};
    vecs[5]  = '{4'b0101, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0};
    vecs[6]  = '{4'b0110, 16'hAAAA, 16'hFFFF, 1'b0, 16'h5555, 1'b0};
    vecs[7]  = '{4'b0111, 16'h1234, 16'h0000, 1'b1, 16'hEDCB, 1'b0};
    vecs[8]  = '{4'b1000, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b1};
    vecs[9]  = '{4'b1000, 16'h4000, 16'h0000, 1'b1, 16'h8001, 1'b0};
    vecs[10] = '{4'b1100, 16'h8001, 16'h0000, 1'b0, 16'h4000, 1'b1};
    vecs[11] = '{4'b1100, 16'h0002, 16'h0000, 1'b1, 16'h8001, 1'b0};

    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_cin = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res", {15'b0, res_cout, res_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("idle_alu", {11'b0, alu_a, alu_b, alu_op, alu_cin}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      $display("vec %0d op=%b a=%h b=%h cin=%b -> q=%h cout=%b", i, vecs[i].op,
               vecs[i].a, vecs[i].b, vecs[i].cin, res_q, res_cout);
      check("early_valid", {30'b0, rv0, rv1}, 32'd0);
      check("lat_valid", {31'b0, res_valid}, 32'd1);
      check("res_q", {16'b0, res_q}, {16'b0, vecs[i].q});
      check("res_cout", {31'b0, res_cout}, {31'b0, vecs[i].cout});
      check("done_alu", {11'b0, alu_a, alu_b, alu_op, alu_cin}, 32'd0);
      check("done_ready", {31'b0, req_ready}, 32'd0);
      consume();
      check("retain_q", {16'b0, res_q}, {16'b0, vecs[i].q});
    end

    // Carry-use forced on the upper add byte
    run_op(4'b0000, 16'h00FF, 16'h0001, 1'b0);
    $display("seq add-chain op0=%b op1=%b cin1=%b", step_op0, step_op1, step_cin1);
    check("add_op0", {28'b0, step_op0}, 32'h0);
    check("add_op1", {28'b0, step_op1}, 32'h1);
    check("add_cin1", {31'b0, step_cin1}, 32'd1);
    consume();

    // Result held while the consumer stalls
    run_op(4'b0000, 16'hFFFF, 16'h0001, 1'b0);
    for (int c = 0; c < 3; c++) begin
      $display("seq hold cycle %0d valid=%b q=%h cout=%b", c, res_valid, res_q, res_cout);
      check("hold_valid", {31'b0, res_valid}, 32'd1);
      check("hold_res", {15'b0, res_cout, res_q}, 32'h10000);
      check("hold_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    consume();

    // Right shift walks high byte first
    run_op(4'b1100, 16'h8001, 16'h0000, 1'b0);
    $display("seq shr a0=%h a1=%h q=%h cout=%b", step_a0, step_a1, res_q, res_cout);
    check("shr_a0", {24'b0, step_a0}, 32'h80);
    check("shr_a1", {24'b0, step_a1}, 32'h01);
    consume();

    // Bitwise uses request cin on every byte
    run_op(4'b0111, 16'h1234, 16'h0000, 1'b1);
    $display("seq bitwise cin0=%b cin1=%b q=%h", step_cin0, step_cin1, res_q);
    check("bw_cin", {30'b0, step_cin0, step_cin1}, 32'd3);
    consume();

    // Reset during the second RUN cycle discards the operation
    @(negedge clk);
    req_op = 4'b0000; req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_run_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    $display("seq abort valid=%b q=%h", res_valid, res_q);
    check("abort_valid", {31'b0, res_valid}, 32'd0);
    check("abort_res", {15'b0, res_cout, res_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_nopulse", {31'b0, res_valid}, 32'd0);
    end
    run_op(4'b0001, 16'h1234, 16'h0FF0, 1'b1);
    $display("seq after-abort q=%h cout=%b", res_q, res_cout);
    check("after_abort", {15'b0, res_cout, res_q}, 32'h2225);
    consume();

    // Continuous request with an always-ready consumer
    req_valid = 1'b1; res_ready = 1'b1; req_b = 16'h0010; req_op = 4'b0000; req_cin = 1'b0;
    last_acc = -1; n_acc = 0; n_res = 0; exp_sum = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      req_a = 16'h0100 + 16'(c);
      if (req_ready) begin
        if (last_acc >= 0) check("acc_gap", 32'(c - last_acc), 32'd4);
        last_acc = c;
        n_acc++;
        exp_sum = req_a + 16'h0010;
      end
      @(posedge clk); #1;
      if (res_valid) begin
        n_res++;
        $display("seq stream cycle %0d q=%h", c, res_q);
        check("stream_res", {16'b0, res_q}, {16'b0, exp_sum});
      end
    end
    req_valid = 1'b0; res_ready = 1'b0;
    check("stream_accepts", 32'(n_acc), 32'd4);
    check("stream_results", 32'(n_res), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
